manchester_encoder: RTL and testbench

Manchester transmitter for the smart-LED serial line. It serializes DATA_WIDTH-bit words, MSB first, into Manchester symbols of BIT_LENGTH clocks each. Each bit drives its value for the first half-bit and the inverse for the second half, so there is always a mid-bit transition. It sits at the output of the LED pixel chain and drives the downstream device's Manchester decoder, which must be configured with the same BIT_LENGTH.

---
 rtl/manchester_encoder.sv | 133 +++++++++++++
 tb/tb_manchester_encoder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/manchester_encoder.sv
// Manchester transmitter: serializes DATA_WIDTH-bit words MSB first, BIT_LENGTH clocks per bit.
// Define MANCHESTER_ENCODER_PREAMBLE_EN to prefix each word accepted from idle with a 1,0 sync preamble.
module manchester_encoder #(
  parameter int BIT_LENGTH = 24,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out,
  output logic                  out_busy,
  output logic                  out_done
);

  localparam int H  = BIT_LENGTH / 2;
  localparam int PW = (H > 1) ? $clog2(H) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(H - 1);
  localparam logic [BW-1:0] BIT_MSB = BW'(DATA_WIDTH - 1);

`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PRE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1} state_t;
`endif

  state_t                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic                  half_q, half_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  out_q, out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic last_cycle;
  logic hs;

  assign last_cycle = half_q && (phase_q == PH_LAST) && (bit_q == '0);
  assign in_ready   = rst_n && ((state_q == S_IDLE) || ((state_q == S_DATA) && last_cycle));
  assign hs         = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          shift_d = in_data;
          phase_d = '0;
          half_d  = 1'b0;
`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
          state_d = S_PRE;
          bit_d   = BW'(1);
`else
          state_d = S_DATA;
          bit_d   = BIT_MSB;
`endif
        end
      end
      default: begin
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + 1'b1;
        end else begin
          phase_d = '0;
          half_d  = ~half_q;
          if (half_q) begin
            if (bit_q != '0) begin
              bit_d = bit_q - 1'b1;
              if (state_q == S_DATA) shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            end else if ((state_q == S_DATA) && hs) begin
              // back-to-back word: reload without leaving DATA so no gap appears
              shift_d = in_data;
              bit_d   = BIT_MSB;
            end else if (state_q == S_DATA) begin
              state_d = S_IDLE;
              bit_d   = '0;
            end else begin
              state_d = S_DATA;
              bit_d   = BIT_MSB;
            end
          end
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    out_d = 1'b0;
    case (state_d)
      S_DATA: out_d = shift_d[DATA_WIDTH-1] ^ half_d;
`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
      S_PRE:  out_d = bit_d[0] ^ half_d;
`endif
      default: out_d = 1'b0;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DATA) && half_d && (phase_d == PH_LAST) && (bit_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out      = out_q;
  assign out_busy = busy_q;
  assign out_done = done_q;

endmodule

// File: tb/tb_manchester_encoder.sv
// Directed bench for manchester_encoder, BIT_LENGTH=8, DATA_WIDTH=8, default (no preamble) build.
module tb_manchester_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic       out_busy;
  logic       out_done;

  int n_checks = 0;
  int n_fail   = 0;

  manchester_encoder #(.BIT_LENGTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_busy(out_busy), .out_done(out_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // Half-bit patterns, MSB-first: bit 1 -> "10", bit 0 -> "01".
  typedef struct {
    logic [7:0]  word;
    logic [15:0] pat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_ready);
    chk({tag, " out"}, 32'(out), 32'd0);
    chk({tag, " busy"}, 32'(out_busy), 32'd0);
    chk({tag, " done"}, 32'(out_done), 32'd0);
    chk({tag, " ready"}, 32'(in_ready), 32'(exp_ready));
  endtask

  // Called right after the handshake inputs were set; walks the 64 cycles of the word.
  task automatic check_word(input string tag, input logic [15:0] pat, input bit hold_junk,
                            input logic [7:0] next_data, input bit next_valid, input int abort_at);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk($sformatf("%s out c%0d", tag, k), 32'(out), 32'(pat[15 - (k - 1) / 4]));
      chk($sformatf("%s busy c%0d", tag, k), 32'(out_busy), 32'd1);
      chk($sformatf("%s done c%0d", tag, k), 32'(out_done), 32'(k == 64));
      chk($sformatf("%s ready c%0d", tag, k), 32'(in_ready), 32'(k == 64));
      if (k == abort_at) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        return;
      end
      if (k == 64) begin
        in_data  = next_data;
        in_valid = next_valid;
      end else if (hold_junk) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic start_word(input string tag, input logic [7:0] w);
    @(negedge clk);
    chk({tag, " ready before hs"}, 32'(in_ready), 32'd1);
    in_data  = w;
    in_valid = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 16'h9966};
    vecs[1] = '{8'h00, 16'h5555};
    vecs[2] = '{8'hFF, 16'hAAAA};
    vecs[3] = '{8'h3C, 16'h5AA5};
    vecs[4] = '{8'h81, 16'h9556};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post-reset", 1'b1);

    // Single words from idle, each followed by a return to idle.
    for (int i = 0; i < 5; i++) begin
      start_word($sformatf("vec%0d", i), vecs[i].word);
      check_word($sformatf("vec%0d", i), vecs[i].pat, 1'b0, 8'h00, 1'b0, 0);
      @(negedge clk);
      check_idle($sformatf("vec%0d end", i), 1'b1);
    end

    // Back-to-back 0xFF then 0x00 with valid held: no gap, second word starts LLLLHHHH.
    start_word("b2b", 8'hFF);
    check_word("b2b w0", 16'hAAAA, 1'b0, 8'h00, 1'b1, 0);
    check_word("b2b w1", 16'h5555, 1'b0, 8'h00, 1'b0, 0);
    @(negedge clk);
    check_idle("b2b end", 1'b1);

    // Valid held with toggling data while not ready: word unaffected, no extra handshake.
    start_word("junk", 8'hA5);
    check_word("junk", 16'h9966, 1'b1, 8'h00, 1'b0, 0);
    @(negedge clk);
    check_idle("junk end", 1'b1);
    @(negedge clk);
    check_idle("junk end+1", 1'b1);

    // Reset asserted in cycle 20 of a word discards it.
    start_word("rst", 8'hA5);
    check_word("rst", 16'h9966, 1'b0, 8'h00, 1'b0, 20);
    @(negedge clk);
    check_idle("rst mid", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst release", 1'b1);
    start_word("rst after", 8'h3C);
    check_word("rst after", 16'h5AA5, 1'b0, 8'h00, 1'b0, 0);
    @(negedge clk);
    check_idle("rst after end", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
